pattern_generator: RTL and testbench
====================================

PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 Parameter WIDTH, 8, width of the pattern register, in bits.
REQ-002 Parameter GAP, 1, number of idle zero-bit cycles inserted between repetitions; 0 means no gap.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to transmit; sampled on the rising edge of clk.
REQ-006 pat  input  WIDTH  pattern to serialize; bit len-1 is sent first.
REQ-007 len  input  ceil(log2(WIDTH+1))  number of pattern bits per repetition; legal range 1..WIDTH.
REQ-008 reps  input  4  repetition count; 1..15 sends that many repetitions, 0 repeats continuously.
REQ-009 abort  input  1  terminates an active transmission.
REQ-010 nwbit  output  1  registered serial bit stream.
REQ-011 valid  output  1  high on cycles where nwbit carries a pattern bit.
REQ-012 busy  output  1  high while a transmission is in progress, including gap cycles.
REQ-013 done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-015 All outputs SHALL be registered.
REQ-016 In IDLE, nwbit, valid and busy SHALL be 0.
REQ-017 start sampled high in IDLE with abort low and len within 1..WIDTH SHALL capture pat, len and reps internally and enter SHIFT.
- On that same edge: nwbit=pat[len-1], valid=1, busy=1.
- The first bit is therefore visible one cycle after start is sampled.
REQ-018 start with len=0 or len>WIDTH SHALL be ignored: state stays IDLE, no done pulse.
REQ-019 In SHIFT, one bit SHALL be emitted per cycle, MSB-first, from captured bit len-1 down to bit 0; valid=1 on every SHIFT cycle.
REQ-020 pat, len, reps and start changes while busy=1 SHALL have no effect on the transmission in progress.
REQ-021 After bit 0, if further repetitions remain (or captured reps=0) and GAP>0, the FSM SHALL enter GAP for exactly GAP cycles (nwbit=0, valid=0, busy=1) and then restart SHIFT at bit len-1.
REQ-022 With GAP=0, the next repetition's bit len-1 SHALL follow bit 0 on the very next cycle.
REQ-023 After bit 0 of the final repetition, the next edge SHALL enter IDLE, and in that first IDLE cycle:
- done=1 for exactly one cycle;
- busy=0, valid=0, nwbit=0.
REQ-024 start sampled in the done cycle SHALL be accepted (back-to-back frames) with the same 1-cycle latency.
REQ-025 abort sampled high while busy SHALL force IDLE on the next edge with nwbit=0, valid=0 and busy=0; no done pulse SHALL be generated.
REQ-026 abort and start sampled high together in IDLE: abort SHALL win and the FSM SHALL stay IDLE.
REQ-027 With reps=0, transmission SHALL continue indefinitely until abort or reset.
REQ-028 The repetition counter SHALL not wrap.
REQ-029 Illegal or unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force state IDLE and clear nwbit, valid, busy, done and all internal counters and capture registers to 0.
REQ-031 start SHALL be ignored while rst_n is low.
REQ-032 Reset asserted mid-transmission SHALL truncate the frame with no done pulse.
REQ-033 The first start accepted SHALL be on the first rising edge with rst_n high.

Verification
REQ-034 pat=8'h05, len=3, reps=1, GAP=1, 1-cycle start -> nwbit 1,0,1 with valid=1 on cycles 1-3; done=1 and busy=0 on cycle 4.
REQ-035 pat=8'h05, len=3, reps=2, GAP=1 -> nwbit 1,0,1,0,1,0,1; valid 1,1,1,0,1,1,1; done on cycle 8.
REQ-036 reps=0, len=2, pat=8'h02, abort at cycle 10 -> alternating 1,0 stream until cycle 10; IDLE on cycle 11; done never asserted.
REQ-037 start with len=0, and separately with len=9 -> busy, valid and done stay 0.
REQ-038 rst_n driven low between clock edges during SHIFT -> nwbit, valid and busy go 0 without waiting for clk; start 2 cycles after release -> normal frame.
REQ-039 start held high through a 3-bit frame with reps=1 -> the in-flight frame is unchanged; a second frame begins the cycle after done.

Source files
------------

// File: rtl/pattern_generator_if.sv
// Bus bundle for the serial pattern generator: request/control inputs
// and the registered serial-stream outputs.
interface pattern_generator_if #(
    parameter int WIDTH = 8
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [3:0]       reps;
    logic             abort;
    logic             nwbit;
    logic             valid;
    logic             busy;
    logic             done;

    // Requester side: drives the request, observes the stream.
    modport master (
        output start, pat, len, reps, abort,
        input  nwbit, valid, busy, done
    );

    // Generator side: samples the request, drives the stream.
    modport slave (
        input  start, pat, len, reps, abort,
        output nwbit, valid, busy, done
    );
endinterface

// File: rtl/pattern_generator.sv
// Serial pattern generator: shifts out bits len-1..0 of a captured pattern,
// MSB first, for a programmable number of repetitions (0 = endless), with
// GAP idle cycles between repetitions. All outputs are registered.
module pattern_generator #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    pattern_generator_if.slave   bus
);
    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Pick one bit of a pattern by a len-sized index without an
    // over-wide bit select.
    function automatic logic get_bit(input logic [WIDTH-1:0] v,
                                     input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == LEN_W'(i)) begin
                b = v[i];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] pat_r, pat_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic [3:0]       reps_r, reps_s;
    logic             cont_r, cont_s;
    logic [LEN_W-1:0] idx_r, idx_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic             nwbit_r, nwbit_s;
    logic             valid_r, valid_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             len_ok_s;
    logic             last_rep_s;

    // Request is only legal when the requested length is 1..WIDTH.
    assign len_ok_s = (bus.len != LEN_ZERO) && (bus.len <= LEN_MAX);

    // Current repetition is the final one (reps counts remaining, incl. current).
    assign last_rep_s = !cont_r && (reps_r <= 4'd1);

    // Next-state, capture and output computation for the three-state FSM.
    always_comb begin
        state_s = state_r;
        pat_s   = pat_r;
        len_s   = len_r;
        reps_s  = reps_r;
        cont_s  = cont_r;
        idx_s   = idx_r;
        gap_s   = gap_r;
        nwbit_s = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort && len_ok_s) begin
                    state_s = ST_SHIFT;
                    pat_s   = bus.pat;
                    len_s   = bus.len;
                    reps_s  = bus.reps;
                    cont_s  = (bus.reps == 4'd0);
                    idx_s   = bus.len - LEN_ONE;
                    gap_s   = GAP_LAST;
                    nwbit_s = get_bit(bus.pat, bus.len - LEN_ONE);
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (idx_r != LEN_ZERO) begin
                    idx_s   = idx_r - LEN_ONE;
                    nwbit_s = get_bit(pat_r, idx_r - LEN_ONE);
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                end else if (last_rep_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    // Endless mode never decrements, so the count cannot wrap.
                    reps_s = cont_r ? reps_r : (reps_r - 4'd1);
                    busy_s = 1'b1;
                    if (GAP > 0) begin
                        state_s = ST_GAP;
                        gap_s   = GAP_LAST;
                    end else begin
                        idx_s   = len_r - LEN_ONE;
                        nwbit_s = get_bit(pat_r, len_r - LEN_ONE);
                        valid_s = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (gap_r == {GAP_W{1'b0}}) begin
                    state_s = ST_SHIFT;
                    idx_s   = len_r - LEN_ONE;
                    nwbit_s = get_bit(pat_r, len_r - LEN_ONE);
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    gap_s  = gap_r - GAP_W'(1);
                    busy_s = 1'b1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                pat_s   = {WIDTH{1'b0}};
                len_s   = LEN_ZERO;
                reps_s  = 4'd0;
                cont_s  = 1'b0;
                idx_s   = LEN_ZERO;
                gap_s   = {GAP_W{1'b0}};
            end
        endcase
    end

    // State, capture, counter and output registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pat_r   <= {WIDTH{1'b0}};
            len_r   <= LEN_ZERO;
            reps_r  <= 4'd0;
            cont_r  <= 1'b0;
            idx_r   <= LEN_ZERO;
            gap_r   <= {GAP_W{1'b0}};
            nwbit_r <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pat_r   <= pat_s;
            len_r   <= len_s;
            reps_r  <= reps_s;
            cont_r  <= cont_s;
            idx_r   <= idx_s;
            gap_r   <= gap_s;
            nwbit_r <= nwbit_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.nwbit = nwbit_r;
    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator (WIDTH=8, GAP=1): a cycle table of
// {inputs, expected nwbit/valid/busy/done} plus hand-written sequences for
// reset, endless mode with abort, and asynchronous reset mid-frame.
module tb_pattern_generator;
    localparam int WIDTH = 8;
    localparam int GAP   = 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pattern_generator_if #(.WIDTH(WIDTH)) bus ();

    pattern_generator #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] reps;
        logic       abort;
        logic [3:0] exp;   // {nwbit, valid, busy, done}
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic s, input logic [7:0] p, input logic [3:0] l,
                                input logic [3:0] r, input logic a, input logic [3:0] e);
        vec_t v;
        v.start = s; v.pat = p; v.len = l; v.reps = r; v.abort = a; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.nwbit, bus.valid, bus.busy, bus.done};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: {nwbit,valid,busy,done} got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input logic a);
        @(negedge clk);
        bus.start = s; bus.pat = p; bus.len = l; bus.reps = r; bus.abort = a;
    endtask

    task automatic step_check(input string name, input logic [3:0] exp);
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        logic [3:0] cont_exp [3];

        rst_n = 1'b0;
        bus.start = 1'b0; bus.pat = 8'h00; bus.len = 4'd0; bus.reps = 4'd0; bus.abort = 1'b0;

        // Single frame, reps=1
        vecs.push_back(mk(1'b1, 8'h05, 4'd3, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd1, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd1, 1'b0, 4'b0001));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd1, 1'b0, 4'b0000));
        // Two repetitions with one gap cycle
        vecs.push_back(mk(1'b1, 8'h05, 4'd3, 4'd2, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b0010));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd2, 1'b0, 4'b0001));
        // Illegal lengths ignored
        vecs.push_back(mk(1'b1, 8'h05, 4'd0, 4'd1, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b1, 8'h05, 4'd9, 4'd1, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd1, 1'b0, 4'b0000));
        // start held high; inputs change while busy; back-to-back frame
        vecs.push_back(mk(1'b1, 8'h05, 4'd3, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b1, 8'hFF, 4'd8, 4'd3, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b1, 8'hFF, 4'd8, 4'd3, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b1, 8'h05, 4'd3, 4'd1, 1'b0, 4'b0001));
        vecs.push_back(mk(1'b1, 8'h06, 4'd3, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h06, 4'd3, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h06, 4'd3, 4'd1, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'h06, 4'd3, 4'd1, 1'b0, 4'b0001));
        // abort and start together in IDLE
        vecs.push_back(mk(1'b1, 8'h05, 4'd3, 4'd1, 1'b1, 4'b0000));
        vecs.push_back(mk(1'b0, 8'h05, 4'd3, 4'd1, 1'b0, 4'b0000));
        // Full-width frame 8'hA5 -> 1,0,1,0,0,1,0,1
        vecs.push_back(mk(1'b1, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b0110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'hA5, 4'd8, 4'd1, 1'b0, 4'b0001));
        // len=1, reps=2: bit, gap, bit, done
        vecs.push_back(mk(1'b1, 8'h01, 4'd1, 4'd2, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h01, 4'd1, 4'd2, 1'b0, 4'b0010));
        vecs.push_back(mk(1'b0, 8'h01, 4'd1, 4'd2, 1'b0, 4'b1110));
        vecs.push_back(mk(1'b0, 8'h01, 4'd1, 4'd2, 1'b0, 4'b0001));
        vecs.push_back(mk(1'b0, 8'h01, 4'd1, 4'd2, 1'b0, 4'b0000));

        // Reset state, start ignored while in reset
        #1;
        check("reset_state", 4'b0000);
        drive(1'b1, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("start_during_reset", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step_check("first_edge_after_reset", 4'b1110);
        drive(1'b0, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("post_reset_bit1", 4'b0110);
        step_check("post_reset_bit0", 4'b1110);
        step_check("post_reset_done", 4'b0001);
        step_check("post_reset_idle", 4'b0000);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].pat, vecs[i].len, vecs[i].reps, vecs[i].abort);
            step_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Endless mode: pat=2'b10 with gap, run beyond 15 repetitions, abort in GAP
        cont_exp[0] = 4'b1110;
        cont_exp[1] = 4'b0110;
        cont_exp[2] = 4'b0010;
        for (int k = 0; k < 60; k++) begin
            if (k == 0) begin
                drive(1'b1, 8'h02, 4'd2, 4'd0, 1'b0);
            end else begin
                drive(1'b0, 8'hFF, 4'd8, 4'd5, 1'b0);
            end
            step_check($sformatf("endless_c%0d", k), cont_exp[k % 3]);
        end
        drive(1'b0, 8'h02, 4'd2, 4'd0, 1'b1);
        step_check("abort_from_gap", 4'b0000);
        drive(1'b0, 8'h02, 4'd2, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step_check($sformatf("after_abort_idle%0d", k), 4'b0000);
        end

        // Abort during SHIFT
        drive(1'b1, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("abort_shift_start", 4'b1110);
        drive(1'b0, 8'h05, 4'd3, 4'd1, 1'b1);
        step_check("abort_from_shift", 4'b0000);
        drive(1'b0, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("abort_no_done", 4'b0000);

        // Asynchronous reset between edges during SHIFT, then a normal frame
        drive(1'b1, 8'hFF, 4'd8, 4'd1, 1'b0);
        step_check("async_pre_bit7", 4'b1110);
        drive(1'b0, 8'hFF, 4'd8, 4'd1, 1'b0);
        step_check("async_pre_bit6", 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step_check("after_release_idle0", 4'b0000);
        drive(1'b0, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("after_release_idle1", 4'b0000);
        drive(1'b1, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("post_async_bit2", 4'b1110);
        drive(1'b0, 8'h05, 4'd3, 4'd1, 1'b0);
        step_check("post_async_bit1", 4'b0110);
        step_check("post_async_bit0", 4'b1110);
        step_check("post_async_done", 4'b0001);
        step_check("post_async_idle", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
